// File: rtl/uart_sample_rx.sv
// UART 8N1 receiver plus frame parser: CA FE, four big-endian 16-bit samples, XOR checksum.
// All four outputs update together only when a whole frame checks out.
module uart_sample_rx #(
    parameter int CLKS_PER_BIT = 12,
    parameter int W            = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_i,
    output logic signed [W-1:0] out0,
    output logic signed [W-1:0] out1,
    output logic signed [W-1:0] out2,
    output logic signed [W-1:0] out3,
    output logic                out_valid,
    output logic                frame_err,
    output logic                chk_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_SYNC0, P_SYNC1, P_PAYLOAD, P_CHECK} p_state_t;

    logic [1:0] sync_q;
    logic       rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx_i};
    end
    assign rxs = sync_q[1];

    // ---------------- bit receiver ----------------
    rx_state_t   rx_state, rx_next;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  shreg, shreg_d;
    logic        byte_stb, stb_d, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            shreg     <= shreg_d;
            byte_stb  <= stb_d;
            frame_err <= ferr_d;
        end
    end

    always_comb begin
        rx_next   = rx_state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shreg_d   = shreg;
        stb_d     = 1'b0;
        ferr_d    = 1'b0;
        case (rx_state)
            RX_IDLE: if (!rxs) begin
                cnt_d   = HALF_M1;
                rx_next = RX_START;
            end
            RX_START: begin
                if (cnt != '0) cnt_d = cnt - 1'b1;
                else if (rxs)  rx_next = RX_IDLE;
                else begin
                    rx_next   = RX_DATA;
                    cnt_d     = FULL_M1;
                    bit_idx_d = '0;
                end
            end
            RX_DATA: begin
                if (cnt != '0) cnt_d = cnt - 1'b1;
                else begin
                    shreg_d   = {rxs, shreg[7:1]};
                    cnt_d     = FULL_M1;
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt != '0) cnt_d = cnt - 1'b1;
                else if (rxs) begin
                    stb_d   = 1'b1;
                    rx_next = RX_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    rx_next = RX_BREAK;
                end
            end
            RX_BREAK: if (rxs) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // ---------------- frame parser ----------------
    p_state_t        p_state, p_next;
    logic [2:0]      idx, idx_d;
    logic [7:0]      xacc, xacc_d;
    logic [7:0][7:0] shadow, shadow_d;
    logic [3:0][W-1:0] out_q;
    logic            upd_d, cerr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state   <= P_SYNC0;
            idx       <= '0;
            xacc      <= '0;
            shadow    <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            p_state   <= p_next;
            idx       <= idx_d;
            xacc      <= xacc_d;
            shadow    <= shadow_d;
            out_valid <= upd_d;
            chk_err   <= cerr_d;
            // byte 2*ch is the MSB of channel ch
            if (upd_d)
                for (int ch = 0; ch < 4; ch++)
                    out_q[ch] <= {shadow[2*ch], shadow[2*ch+1]};
        end
    end

    always_comb begin
        p_next   = p_state;
        idx_d    = idx;
        xacc_d   = xacc;
        shadow_d = shadow;
        upd_d    = 1'b0;
        cerr_d   = 1'b0;
        if (frame_err) begin
            p_next = P_SYNC0;
        end else if (byte_stb) begin
            case (p_state)
                P_SYNC0: if (shreg == 8'hCA) p_next = P_SYNC1;
                P_SYNC1: begin
                    if (shreg == 8'hFE) begin
                        p_next = P_PAYLOAD;
                        idx_d  = '0;
                        xacc_d = '0;
                    end else if (shreg != 8'hCA) begin
                        p_next = P_SYNC0;
                    end
                end
                P_PAYLOAD: begin
                    shadow_d[idx] = shreg;
                    xacc_d        = xacc ^ shreg;
                    idx_d         = idx + 1'b1;
                    if (idx == 3'd7) p_next = P_CHECK;
                end
                P_CHECK: begin
                    if (shreg == xacc) upd_d  = 1'b1;
                    else               cerr_d = 1'b1;
                    p_next = P_SYNC0;
                end
                default: p_next = P_SYNC0;
            endcase
        end
    end

    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];
endmodule
